// File: rtl/lowact_scan_decoder_pkg.sv
// Shared types, mode constants and the one-cold line decode for the
// active-low scan decoder.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN_ON,
        SCAN_BLANK
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUTS  = 2 ** MAX_SEL_W;

    // Callers truncate the result to their own output count.
    function automatic logic [MAX_OUTS-1:0] one_cold(input logic [MAX_SEL_W-1:0] line);
        return ~({{(MAX_OUTS-1){1'b0}}, 1'b1} << line);
    endfunction

endpackage

// File: rtl/lowact_scan_decoder_if.sv
// Select/output bundle between a controller and the scan decoder.
interface lowact_scan_decoder_if #(
    parameter int SEL_W = 2
);
    localparam int OUTS = 2 ** SEL_W;

    logic             en;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [OUTS-1:0]  y_n;
    logic [SEL_W-1:0] idx;
    logic             wrap;

    modport master (
        output en, mode, sel,
        input  y_n, idx, wrap
    );

    modport slave (
        input  en, mode, sel,
        output y_n, idx, wrap
    );

endinterface

// File: rtl/lowact_scan_decoder_scan_timer.sv
// Dwell counter for scan mode: counts 0..DWELL-1 while inc is high and
// flags the last dwell cycle on tc.
module scan_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic tc
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q;

    assign tc = (cnt_q == TC_VAL);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= tc ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/lowact_scan_decoder.sv
// Active-low N-to-2^N decoder with registered outputs: direct select or an
// autonomous scan with programmable dwell and optional blanking.
module lowact_scan_decoder
    import decoder_pkg::*;
#(
    parameter int SEL_W = 2,
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    lowact_scan_decoder_if.slave   bus
);

    localparam int OUTS = 2 ** SEL_W;

    state_t           state_q, state_d;
    logic [OUTS-1:0]  y_n_q, y_n_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             wrap_q, wrap_d;
    logic             tmr_inc, tmr_clr, tmr_tc;
    logic [SEL_W-1:0] idx_inc;

    function automatic logic [OUTS-1:0] line_n(input logic [SEL_W-1:0] line);
        return OUTS'(one_cold(MAX_SEL_W'(line)));
    endfunction

    scan_timer #(.DWELL(DWELL)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (tmr_inc),
        .clr   (tmr_clr),
        .tc    (tmr_tc)
    );

    assign idx_inc = idx_q + SEL_W'(1);

    // Next-state and next-output values: everything is computed for the
    // state being entered, so y_n/idx are pure registers with no input path.
    always_comb begin
        state_d = state_q;
        y_n_d   = '1;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        tmr_inc = 1'b0;
        tmr_clr = 1'b1;

        if (!bus.en) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (bus.mode == MODE_DIRECT) begin
            state_d = DIRECT;
            y_n_d   = line_n(bus.sel);
            idx_d   = bus.sel;
        end else begin
            case (state_q)
                SCAN_ON: begin
                    tmr_inc = 1'b1;
                    tmr_clr = 1'b0;
                    if (!tmr_tc) begin
                        y_n_d = line_n(idx_q);
                    end else if (BLANK == 1) begin
                        state_d = SCAN_BLANK;
                    end else begin
                        idx_d  = idx_inc;
                        y_n_d  = line_n(idx_inc);
                        wrap_d = &idx_q;
                    end
                end
                SCAN_BLANK: begin
                    state_d = SCAN_ON;
                    idx_d   = idx_inc;
                    y_n_d   = line_n(idx_inc);
                    wrap_d  = &idx_q;
                end
                default: begin
                    state_d = SCAN_ON;
                    idx_d   = '0;
                    y_n_d   = line_n('0);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_n_q   <= '1;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_n_q   <= y_n_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.y_n  = y_n_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_lowact_scan_decoder.sv
// Scoreboard bench: two decoder configurations share one stimulus stream and
// are checked against a time-based model of the scan schedule.
module tb_lowact_scan_decoder;

    typedef struct {
        logic [7:0] y_n;
        logic [2:0] idx;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [2:0] sel;

    int checks = 0;
    int errors = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    lowact_scan_decoder_if #(.SEL_W(2)) bus_a ();
    lowact_scan_decoder_if #(.SEL_W(3)) bus_b ();

    assign bus_a.en   = en;
    assign bus_a.mode = mode;
    assign bus_a.sel  = sel[1:0];
    assign bus_b.en   = en;
    assign bus_b.mode = mode;
    assign bus_b.sel  = sel;

    lowact_scan_decoder #(.SEL_W(2), .DWELL(3), .BLANK(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    lowact_scan_decoder #(.SEL_W(3), .DWELL(1), .BLANK(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    // Expected outputs from the mode and the number of cycles spent scanning:
    // st 0 = idle, 1 = direct, 2 = scan (p = cycles since scan entry).
    function automatic exp_t expect_out(int sw, int dw, int bl, int st, int p, int dsel);
        exp_t r;
        int outs, mask, per, line, phase;
        outs   = 1 << sw;
        mask   = (1 << outs) - 1;
        r.y_n  = 8'(mask);
        r.idx  = 3'd0;
        r.wrap = 1'b0;
        if (st == 1) begin
            r.y_n = 8'(mask & ~(1 << dsel));
            r.idx = 3'(dsel);
        end else if (st == 2) begin
            per   = dw + bl;
            line  = (p / per) % outs;
            phase = p % per;
            r.idx = 3'(line);
            if (phase < dw) r.y_n = 8'(mask & ~(1 << line));
            r.wrap = (phase == 0) && (p > 0) && (line == 0);
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: advances on every rising edge using the inputs that
    // the DUTs sample there.
    initial begin : model
        int st_a = 0, p_a = 0, ds_a = 0;
        int st_b = 0, p_b = 0, ds_b = 0;
        forever begin
            @(posedge clk);
            if (!rst_n || !en) begin
                st_a = 0; p_a = 0;
                st_b = 0; p_b = 0;
            end else if (mode == 1'b0) begin
                st_a = 1; ds_a = int'(sel[1:0]);
                st_b = 1; ds_b = int'(sel);
            end else begin
                if (st_a == 2) p_a++; else begin st_a = 2; p_a = 0; end
                if (st_b == 2) p_b++; else begin st_b = 2; p_b = 0; end
            end
            q_a.push_back(expect_out(2, 3, 1, st_a, p_a, ds_a));
            q_b.push_back(expect_out(3, 1, 0, st_b, p_b, ds_b));
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("a_y_n",  int'(bus_a.y_n),  int'(e.y_n));
                check("a_idx",  int'(bus_a.idx),  int'(e.idx));
                check("a_wrap", int'(bus_a.wrap), int'(e.wrap));
                check("a_onecold", int'($countones(~bus_a.y_n) <= 1), 1);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("b_y_n",  int'(bus_b.y_n),  int'(e.y_n));
                check("b_idx",  int'(bus_b.idx),  int'(e.idx));
                check("b_wrap", int'(bus_b.wrap), int'(e.wrap));
                check("b_onecold", int'($countones(~bus_b.y_n) <= 1), 1);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stimulus
        rst_n = 1'b0; en = 1'b1; mode = 1'b1; sel = 3'd0;
        cycles(2);

        rst_n = 1'b1; mode = 1'b0; sel = 3'd2;
        cycles(1);
        sel = 3'd0;
        cycles(1);

        mode = 1'b1;
        cycles(20);

        en = 1'b0;
        cycles(1);
        en = 1'b1;
        cycles(10);
        en = 1'b0;
        cycles(1);
        en = 1'b1;
        cycles(5);

        mode = 1'b0; sel = 3'd3;
        cycles(2);
        mode = 1'b1;
        cycles(5);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        cycles(3);

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(199) != 0);
            if ($urandom_range(59) == 0) en = ~en;
            else if (!en && $urandom_range(3) == 0) en = 1'b1;
            if ($urandom_range(49) == 0) mode = ~mode;
            sel = 3'($urandom_range(7));
            cycles(1);
        end

        en = 1'b1; mode = 1'b1; rst_n = 1'b1;
        cycles(40);

        #1;
        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
